channel_capture: RTL and testbench

Per-channel edge capture stage feeding the UART transfer arbiter. Synchronises one probe pin, timestamps every level change with a free-running tick counter, and queues 32-bit event words in a small FIFO. Exposes the FIFO head on `data_out` with an `available`/`read` handshake; one instance per channel, concatenated into the arbiter's `data_in`/`available`/`read` buses.

---
 rtl/la_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/channel_capture.sv | 99 +++++++++
 tb/tb_channel_capture.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: event word layout
// and channel limits seen by the UART transfer arbiter.
package la_pkg;

    localparam int TS_W         = 28;
    localparam int W_LEVEL      = 28;
    localparam int W_LOST       = 29;
    localparam int RSV_W        = 2;
    localparam int WORD_W       = RSV_W + 2 + TS_W;
    localparam int MAX_CHANNELS = 4;

    // Reserved bits stay zero; the arbiter stamps the channel index there.
    function automatic logic [WORD_W-1:0] make_word(
        input logic            lost,
        input logic            level,
        input logic [TS_W-1:0] ts
    );
        return {{RSV_W{1'b0}}, lost, level, ts};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word; a push on full is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_next;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok      = pop && !empty;
    assign push_ok     = push && (!full || pop_ok);
    assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, pop_ok};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, push_ok};
            rd_ptr <= rd_ptr_next;
            // New word lands at the head when it is the only one left queued.
            if (push_ok && (wr_ptr == rd_ptr_next)) begin
                dout <= din;
            end else if (pop_ok && (rd_ptr_next != wr_ptr)) begin
                dout <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/channel_capture.sv
// One capture channel: synchronises a probe pin, timestamps level changes and
// queues event words for the UART transfer arbiter.
module channel_capture
    import la_pkg::*;
#(
    parameter int TICK_PRESCALER = 1,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        probe,
    input  logic        enable,
    output logic [31:0] data_out,
    output logic        available,
    input  logic        read,
    output logic        overflow
);

    localparam int PW = (TICK_PRESCALER > 1) ? $clog2(TICK_PRESCALER) : 1;

    logic              s1;
    logic              s2;
    logic              prev;
    logic              enable_q;
    logic              read_q;
    logic              lost_pending;
    logic [PW-1:0]     pre;
    logic [TS_W-1:0]   ts;
    logic              arm;
    logic              edge_evt;
    logic              evt;
    logic              pop_req;
    logic              drop;
    logic              full;
    logic              empty;
    logic [WORD_W-1:0] word;

    assign arm      = enable && !enable_q;
    assign edge_evt = enable && (s2 != prev);
    // An edge in the arm cycle folds into the arm word via the shared s2 level.
    assign evt      = arm || edge_evt;
    assign pop_req  = read && !read_q;
    assign drop     = evt && full && !pop_req;
    assign word     = make_word(lost_pending, s2, ts);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            prev         <= 1'b0;
            enable_q     <= 1'b0;
            read_q       <= 1'b0;
            pre          <= '0;
            ts           <= '0;
            lost_pending <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            s1       <= probe;
            s2       <= s1;
            prev     <= s2;
            enable_q <= enable;
            read_q   <= read;

            if (!enable) begin
                pre <= '0;
                ts  <= '0;
            end else if (pre == PW'(TICK_PRESCALER - 1)) begin
                pre <= '0;
                ts  <= ts + TS_W'(1);
            end else begin
                pre <= pre + PW'(1);
            end

            if (drop) begin
                lost_pending <= 1'b1;
                overflow     <= 1'b1;
            end else if (evt) begin
                lost_pending <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (evt),
        .pop   (pop_req),
        .din   (word),
        .dout  (data_out),
        .full  (full),
        .empty (empty)
    );

    assign available = !empty;

endmodule

// File: tb/tb_channel_capture.sv
// Bench for channel_capture: two instances (prescaler 1 and 3) against an
// event-queue reference model, directed scenarios then random traffic.
module tb_channel_capture;

    localparam int NI    = 2;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        probe;
    logic        enable;
    logic        read;
    logic [31:0] dout0;
    logic [31:0] dout1;
    logic        avail0;
    logic        avail1;
    logic        ovf0;
    logic        ovf1;

    always #5 clk = ~clk;

    channel_capture #(.TICK_PRESCALER(1), .FIFO_DEPTH(DEPTH)) dut0 (
        .i_clk(clk), .i_rst(rst), .probe(probe), .enable(enable),
        .data_out(dout0), .available(avail0), .read(read), .overflow(ovf0)
    );

    channel_capture #(.TICK_PRESCALER(3), .FIFO_DEPTH(DEPTH)) dut1 (
        .i_clk(clk), .i_rst(rst), .probe(probe), .enable(enable),
        .data_out(dout1), .available(avail1), .read(read), .overflow(ovf1)
    );

    // Reference model state
    logic [31:0] mq [NI][DEPTH];
    int          mhead [NI];
    int          mcnt  [NI];
    logic        mlost [NI];
    logic        movf  [NI];
    logic        samp  [3];     // probe values captured at the last three edges
    logic        en_last;
    logic        rd_last;
    int          run;           // enabled cycles since capture was armed

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int presc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mhead[i] = 0;
            mcnt[i]  = 0;
            mlost[i] = 1'b0;
            movf[i]  = 1'b0;
        end
        for (int k = 0; k < 3; k++) samp[k] = 1'b0;
        en_last = 1'b0;
        rd_last = 1'b0;
        run     = 0;
    endtask

    // Applies the effect of the clock edge that just happened.
    task automatic model_edge();
        logic        ev;
        logic        rise;
        logic        lvl;
        logic [27:0] ts;
        lvl  = samp[1];
        ev   = enable && (!en_last || (samp[1] != samp[0]));
        rise = read && !rd_last;
        for (int i = 0; i < NI; i++) begin
            ts = 28'(run / presc(i));
            if (rise && mcnt[i] > 0) begin
                $display("pop ch%0d word=%h", i, mq[i][mhead[i]]);
                mhead[i] = (mhead[i] + 1) % DEPTH;
                mcnt[i]--;
            end
            if (ev) begin
                if (mcnt[i] < DEPTH) begin
                    mq[i][(mhead[i] + mcnt[i]) % DEPTH] = {2'b00, mlost[i], lvl, ts};
                    mcnt[i]++;
                    mlost[i] = 1'b0;
                end else begin
                    mlost[i] = 1'b1;
                    movf[i]  = 1'b1;
                end
            end
        end
        samp[0] = samp[1];
        samp[1] = samp[2];
        samp[2] = probe;
        run     = enable ? run + 1 : 0;
        en_last = enable;
        rd_last = read;
    endtask

    task automatic check_outputs();
        logic [31:0] d;
        logic        a;
        logic        o;
        for (int i = 0; i < NI; i++) begin
            d = (i == 0) ? dout0  : dout1;
            a = (i == 0) ? avail0 : avail1;
            o = (i == 0) ? ovf0   : ovf1;
            chk($sformatf("avail%0d", i), {31'b0, a}, {31'b0, mcnt[i] > 0});
            if (mcnt[i] > 0) chk($sformatf("head%0d", i), d, mq[i][mhead[i]]);
            chk($sformatf("ovf%0d", i), {31'b0, o}, {31'b0, movf[i]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic toggle_steps(input int n);
        for (int k = 0; k < n; k++) begin
            probe = ~probe;
            step();
        end
    endtask

    task automatic read_pulse();
        read = 1'b1;
        step();
        read = 1'b0;
        step();
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        chk({tag, "_avail0"}, {31'b0, avail0}, 32'd0);
        chk({tag, "_dout0"},  dout0, 32'd0);
        chk({tag, "_avail1"}, {31'b0, avail1}, 32'd0);
        chk({tag, "_dout1"},  dout1, 32'd0);
        chk({tag, "_ovf0"},   {31'b0, ovf0}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        probe  = 1'b0;
        enable = 1'b0;
        read   = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_avail", {31'b0, avail0}, 32'd0);
        chk("rst_dout",  dout0, 32'd0);
        chk("rst_ovf",   {31'b0, ovf0}, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Arm word, then a rising edge whose event cycle sees counter 5
        repeat (3) step();
        chk("arm_word",  dout0, 32'h0000_0000);
        chk("arm_avail", {31'b0, avail0}, 32'd1);
        probe = 1'b1;
        repeat (3) step();
        read = 1'b1;
        step();
        read = 1'b0;
        chk("edge_word",    dout0, 32'h1000_0005);
        chk("edge_word_p3", dout1, 32'h1000_0001);
        step();

        // Fill to 16, then edge and read rise in the same cycle
        toggle_steps(15);
        repeat (2) step();
        probe = ~probe;
        step();
        step();
        read = 1'b1;
        step();
        read = 1'b0;
        step();
        chk("full_pop_ovf", {31'b0, ovf0}, 32'd0);

        // Two dropped events, then lost flag on the next accepted word
        toggle_steps(2);
        repeat (2) step();
        chk("ovf_set", {31'b0, ovf0}, 32'd1);
        read_pulse();
        toggle_steps(1);
        repeat (2) step();
        read_pulse();
        toggle_steps(1);
        repeat (2) step();

        // Read held one cycle, then three cycles
        read = 1'b1; step();
        read = 1'b0; step(); step();
        read = 1'b1; step(); step(); step();
        read = 1'b0; step();

        // Drain completely, then read on empty
        repeat (20) read_pulse();
        chk("drained", {31'b0, avail0}, 32'd0);
        read_pulse();
        chk("read_empty", {31'b0, avail0}, 32'd0);

        // Reset with five queued words, then re-arm
        toggle_steps(5);
        repeat (2) step();
        do_reset("mid_rst");
        step();
        chk("rearm_word",  dout0, 32'h0000_0000);
        chk("rearm_avail", {31'b0, avail0}, 32'd1);

        // Random traffic, alternating slow and fast draining
        for (int seg = 0; seg < 6; seg++) begin
            int rp;
            rp = (seg % 2 == 0) ? 5 : 50;
            if (seg == 3) begin
                do_reset("rnd_rst");
            end
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 99) < 2) enable = ~enable;
                if ($urandom_range(0, 2) == 0) probe = ~probe;
                read = ($urandom_range(0, 99) < rp);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
